// File: rtl/count_new_pkg.sv
// Shared definitions for the count_new loadable up/down counter.
package count_new_pkg;

   // One operation is selected per clock edge (reset is handled separately).
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_UP   = 2'd2,
      OP_DOWN = 2'd3
   } op_t;

   // Priority decode: load overrides counting; direction matters only when enabled.
   function automatic op_t decode_op(input logic load, input logic en, input logic up_down);
      op_t op;
      if (load)
         op = OP_LOAD;
      else if (en && up_down)
         op = OP_UP;
      else if (en)
         op = OP_DOWN;
      else
         op = OP_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/count_new.sv
// Loadable WIDTH-bit up/down binary counter with count enable.
// Arithmetic wraps modulo 2^WIDTH; cout comes straight from the state register.
module count_new
   import count_new_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] cin,
   output logic [WIDTH-1:0] cout
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   op_t op;

   // Select this edge's operation from the sampled control inputs.
   always_comb begin
      op = decode_op(load, en, up_down);
   end

   // State register: synchronous active-low clear, then load/count/hold.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cout <= '0;
      end else begin
         unique case (op)
            OP_LOAD: cout <= cin;
            OP_UP:   cout <= cout + ONE;
            OP_DOWN: cout <= cout - ONE;
            default: cout <= cout;
         endcase
      end
   end

endmodule

// File: tb/tb_count_new.sv
// Self-checking bench for count_new: directed plan plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_count_new;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0;
   logic         up_down = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] cin = '0;
   logic [W-1:0] cout;

   int errors = 0;
   int checks = 0;
   int model  = 0;

   count_new #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .up_down (up_down),
      .load    (load),
      .cin     (cin),
      .cout    (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one edge of stimulus, advance the model, and compare.
   // exp >= 0 adds a check against a hand-derived constant from the plan.
   task automatic step(input string tag, input logic r, input logic e, input logic ud,
                       input logic ld, input logic [W-1:0] c, input int exp);
      @(negedge clk);
      rst = r; en = e; up_down = ud; load = ld; cin = c;
      @(posedge clk);
      if (!r)
         model = 0;
      else if (ld)
         model = int'(c);
      else if (e && ud)
         model = (model + 1) % M;
      else if (e)
         model = (model - 1 + M) % M;
      #1;
      check({tag, "/model"}, cout, model[W-1:0]);
      if (exp >= 0)
         check(tag, cout, exp[W-1:0]);
   endtask

   initial begin
      int dir_seq[4];
      int down_seq[5];
      dir_seq  = '{4, 3, 4, 3};
      down_seq = '{2, 1, 0, 15, 14};

      // Reset held for three edges while enabled.
      for (int i = 0; i < 3; i++)
         step("reset_hold", 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 0);

      // Up count with wrap through 15 -> 0.
      for (int i = 0; i < 17; i++)
         step("up_wrap", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, (i + 1) % 16);

      // Down count from zero wraps to all-ones.
      step("clr", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 0);
      step("down_wrap0", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 15);
      step("down_wrap1", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 14);
      step("down_wrap2", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 13);

      // Direction toggling each edge.
      step("ld3", 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 3);
      for (int i = 0; i < 4; i++)
         step("dir_toggle", 1'b1, 1'b1, (i % 2) == 0, 1'b0, 4'd0, dir_seq[i]);

      // Enable low holds regardless of direction.
      step("ld7", 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 7);
      step("hold_up", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 7);
      step("hold_dn", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 7);
      step("reenable", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 8);

      // Reset mid-count beats load and counting.
      step("ld5", 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 5);
      step("rst_mid", 1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 0);
      step("resume", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1);

      // Load priority over counting, and load without enable.
      step("ld_pri", 1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 11);
      step("ld_noen", 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 3);
      for (int i = 0; i < 5; i++)
         step("down_after_ld", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, down_seq[i]);

      // Random load pattern at cin=11 with counting in between.
      for (int i = 0; i < 40; i++) begin
         logic ld;
         ld = $urandom_range(0, 2) == 0;
         step("rand_ld11", 1'b1, 1'b1, 1'($urandom_range(0, 1)), ld, 4'd11, ld ? 11 : -1);
      end

      // Fully random traffic including occasional resets.
      for (int i = 0; i < 400; i++) begin
         step("random", $urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
              W'($urandom_range(0, M - 1)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
